// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared core constants: trap causes, vector offsets, trap FSM states
package riscv_defines;

    // mcause codes for synchronous exceptions (bit 5 is the interrupt flag, clear here)
    localparam logic [5:0] EXC_CAUSE_ILLEGAL = 6'h02;
    localparam logic [5:0] EXC_CAUSE_EBREAK  = 6'h03;
    localparam logic [5:0] EXC_CAUSE_ECALL   = 6'h0B;

    // Offsets into the 256-byte trap-vector page; interrupts use n*4 below 0x80
    localparam logic [7:0] EXC_OFF_ILLEGAL = 8'h84;
    localparam logic [7:0] EXC_OFF_ECALL   = 8'h88;
    localparam logic [7:0] EXC_OFF_EBREAK  = 8'h8C;

    typedef enum logic [1:0] {
        EXC_IDLE = 2'd0,
        EXC_REQ  = 2'd1,
        EXC_SAVE = 2'd2
    } exc_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// rtl/riscv_irq_prio_enc.sv - find-first-one over the interrupt lines, lowest index wins
// Ports:
//   irq   in  N_IRQ     level interrupt requests
//   valid out 1         at least one line asserted
//   id    out IRQ_BITS  index of the lowest asserted line (0 when none)
module riscv_irq_prio_enc #(
    parameter int N_IRQ    = 32,
    parameter int IRQ_BITS = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0]    irq,
    output logic                valid,
    output logic [IRQ_BITS-1:0] id
);

    // Scan from the top down so the lowest asserted index is the last one written
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                valid = 1'b1;
                id    = IRQ_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_exc_irq_ctrl.sv
// rtl/riscv_exc_irq_ctrl.sv - trap arbiter between the ID controller and the CSRs
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   boot_addr_i                   trap-vector base (bits [31:8] used)
//   irq_i, irq_enable_i           level interrupts, global interrupt enable
//   id_valid_i + *_insn_i         decoded instruction class in ID
//   exc_req_o / exc_ack_i         flush handshake with the controller
//   exc_save_if_o/_id_o           mepc source strobe (IF PC / ID PC)
//   exc_restore_o                 mstatus restore on eret
//   save_exc_cause_o, exc_cause_o mcause strobe and {irq, code}
//   pc_set_o, trap_addr_o         PC redirect to the trap vector
//   irq_ack_o, irq_id_o           accepted-interrupt pulse and id
module riscv_exc_irq_ctrl #(
    parameter int N_IRQ    = 32,
    parameter int IRQ_BITS = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         boot_addr_i,
    input  logic [N_IRQ-1:0]    irq_i,
    input  logic                irq_enable_i,
    input  logic                id_valid_i,
    input  logic                illegal_insn_i,
    input  logic                ecall_insn_i,
    input  logic                ebrk_insn_i,
    input  logic                eret_insn_i,
    output logic                exc_req_o,
    input  logic                exc_ack_i,
    output logic                exc_save_if_o,
    output logic                exc_save_id_o,
    output logic                exc_restore_o,
    output logic                save_exc_cause_o,
    output logic [5:0]          exc_cause_o,
    output logic                pc_set_o,
    output logic [31:0]         trap_addr_o,
    output logic                irq_ack_o,
    output logic [IRQ_BITS-1:0] irq_id_o
);
    import riscv_defines::*;

    exc_state_e          state_q, state_d;
    logic                is_irq_q;
    logic [5:0]          cause_q;
    logic [31:0]         addr_q;
    logic [IRQ_BITS-1:0] id_q;

    logic                prio_valid;
    logic [IRQ_BITS-1:0] prio_id;
    logic [4:0]          prio_id5;
    logic                sync_exc, irq_take, eret_valid, latch;
    logic [5:0]          new_cause;
    logic [7:0]          new_off;

    // Vector page is 256-byte aligned; the low base bits are intentionally dropped
    logic unused_boot_lsb;
    assign unused_boot_lsb = ^boot_addr_i[7:0];

    riscv_irq_prio_enc #(
        .N_IRQ    (N_IRQ),
        .IRQ_BITS (IRQ_BITS)
    ) u_prio (
        .irq   (irq_i),
        .valid (prio_valid),
        .id    (prio_id)
    );

    assign prio_id5   = 5'(prio_id);
    assign sync_exc   = id_valid_i & (illegal_insn_i | ecall_insn_i | ebrk_insn_i);
    assign irq_take   = irq_enable_i & prio_valid;
    assign eret_valid = id_valid_i & eret_insn_i;

    // Source selection: any sync exception beats any interrupt
    always_comb begin
        new_cause = {1'b1, prio_id5};
        new_off   = {1'b0, prio_id5, 2'b00};
        if (id_valid_i && illegal_insn_i) begin
            new_cause = EXC_CAUSE_ILLEGAL;
            new_off   = EXC_OFF_ILLEGAL;
        end else if (id_valid_i && ecall_insn_i) begin
            new_cause = EXC_CAUSE_ECALL;
            new_off   = EXC_OFF_ECALL;
        end else if (id_valid_i && ebrk_insn_i) begin
            new_cause = EXC_CAUSE_EBREAK;
            new_off   = EXC_OFF_EBREAK;
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            EXC_IDLE: begin
                // An eret in ID owns this cycle; a pending trap is picked up next cycle
                if (!eret_valid && (sync_exc || irq_take)) begin
                    latch   = 1'b1;
                    state_d = EXC_REQ;
                end
            end
            EXC_REQ: begin
                if (exc_ack_i) begin
                    state_d = EXC_SAVE;
                end else if (is_irq_q && !irq_enable_i) begin
                    state_d = EXC_IDLE;
                end
            end
            EXC_SAVE: state_d = EXC_IDLE;
            default:  state_d = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EXC_IDLE;
            is_irq_q <= 1'b0;
            cause_q  <= '0;
            addr_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                is_irq_q <= !sync_exc;
                cause_q  <= new_cause;
                addr_q   <= {boot_addr_i[31:8], new_off};
                if (!sync_exc) begin
                    id_q <= prio_id;
                end
            end
        end
    end

    // Strobes are decoded from the state register and masked while reset is held
    assign exc_req_o        = !rst && (state_q == EXC_REQ);
    assign save_exc_cause_o = !rst && (state_q == EXC_SAVE);
    assign pc_set_o         = save_exc_cause_o;
    assign exc_save_id_o    = save_exc_cause_o && !is_irq_q;
    assign exc_save_if_o    = save_exc_cause_o && is_irq_q;
    assign irq_ack_o        = save_exc_cause_o && is_irq_q;
    assign exc_restore_o    = !rst && eret_valid && (state_q == EXC_IDLE);

    assign exc_cause_o = cause_q;
    assign trap_addr_o = addr_q;
    assign irq_id_o    = id_q;

endmodule

// File: tb/tb_riscv_exc_irq_ctrl.sv
// tb/tb_riscv_exc_irq_ctrl.sv - directed self-checking bench for riscv_exc_irq_ctrl
module tb_riscv_exc_irq_ctrl;

    localparam int N_IRQ    = 32;
    localparam int IRQ_BITS = 5;
    localparam logic [31:0] BOOT = 32'h1C00_8012;
    localparam logic [31:0] BASE = 32'h1C00_8000;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         boot_addr_i;
    logic [N_IRQ-1:0]    irq_i;
    logic                irq_enable_i, id_valid_i;
    logic                illegal_insn_i, ecall_insn_i, ebrk_insn_i, eret_insn_i;
    logic                exc_req_o, exc_ack_i;
    logic                exc_save_if_o, exc_save_id_o, exc_restore_o;
    logic                save_exc_cause_o, pc_set_o, irq_ack_o;
    logic [5:0]          exc_cause_o;
    logic [31:0]         trap_addr_o;
    logic [IRQ_BITS-1:0] irq_id_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    riscv_exc_irq_ctrl #(.N_IRQ(N_IRQ)) dut (
        .clk              (clk),
        .rst              (rst),
        .boot_addr_i      (boot_addr_i),
        .irq_i            (irq_i),
        .irq_enable_i     (irq_enable_i),
        .id_valid_i       (id_valid_i),
        .illegal_insn_i   (illegal_insn_i),
        .ecall_insn_i     (ecall_insn_i),
        .ebrk_insn_i      (ebrk_insn_i),
        .eret_insn_i      (eret_insn_i),
        .exc_req_o        (exc_req_o),
        .exc_ack_i        (exc_ack_i),
        .exc_save_if_o    (exc_save_if_o),
        .exc_save_id_o    (exc_save_id_o),
        .exc_restore_o    (exc_restore_o),
        .save_exc_cause_o (save_exc_cause_o),
        .exc_cause_o      (exc_cause_o),
        .pc_set_o         (pc_set_o),
        .trap_addr_o      (trap_addr_o),
        .irq_ack_o        (irq_ack_o),
        .irq_id_o         (irq_id_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] strobes();
        return {exc_req_o, exc_save_if_o, exc_save_id_o, exc_restore_o,
                save_exc_cause_o, pc_set_o, irq_ack_o, 1'b0};
    endfunction

    // Sync exception with irq_i[0] pending; IE dropped in REQ must not cancel it
    task automatic run_sync(input logic ill, input logic ec, input logic eb,
                            input logic [5:0] exp_cause, input logic [7:0] exp_off);
        irq_i = 32'h1; irq_enable_i = 1'b1;
        id_valid_i = 1'b1; illegal_insn_i = ill; ecall_insn_i = ec; ebrk_insn_i = eb;
        tick();
        chk("sync_req", exc_req_o, 1);
        chk("sync_cause", exc_cause_o, exp_cause);
        chk("sync_addr", trap_addr_o, BASE | exp_off);
        irq_i = '0; id_valid_i = 1'b0; illegal_insn_i = 0; ecall_insn_i = 0; ebrk_insn_i = 0;
        irq_enable_i = 1'b0;
        tick();
        chk("sync_no_cancel", exc_req_o, 1);
        exc_ack_i = 1'b1;
        tick();
        chk("sync_save_strobes", strobes(), 8'b0010_1100);
        exc_ack_i = 1'b0; irq_enable_i = 1'b1;
        tick();
        chk("sync_idle", strobes(), 8'h00);
    endtask

    initial begin
        rst = 1'b1; boot_addr_i = BOOT; irq_i = '0; irq_enable_i = 1'b0;
        id_valid_i = 0; illegal_insn_i = 0; ecall_insn_i = 0; ebrk_insn_i = 0;
        eret_insn_i = 0; exc_ack_i = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_strobes", strobes(), 8'h00);
        chk("rst_cause", exc_cause_o, 0);
        chk("rst_addr", trap_addr_o, 0);
        chk("rst_id", irq_id_o, 0);

        // Ack in IDLE is ignored
        exc_ack_i = 1'b1;
        tick();
        chk("idle_ack", strobes(), 8'h00);
        exc_ack_i = 1'b0;

        // Lines 4 and 5, ack two cycles after request
        irq_i = 32'h0000_0030; irq_enable_i = 1'b1;
        tick();
        chk("irq4_req", exc_req_o, 1);
        chk("irq4_cause", exc_cause_o, 6'h24);
        chk("irq4_id", irq_id_o, 4);
        chk("irq4_addr", trap_addr_o, BASE | 32'h10);
        irq_i = '0;
        tick();
        chk("irq4_hold", exc_req_o, 1);
        exc_ack_i = 1'b1;
        tick();
        chk("irq4_save", strobes(), 8'b0100_1110);
        tick();
        chk("irq4_one_cycle", strobes(), 8'h00);
        chk("irq4_cause_held", exc_cause_o, 6'h24);
        exc_ack_i = 1'b0;

        run_sync(1'b1, 1'b1, 1'b0, 6'h02, 8'h84);
        run_sync(1'b0, 1'b1, 1'b1, 6'h0B, 8'h88);
        run_sync(1'b0, 1'b0, 1'b1, 6'h03, 8'h8C);

        // Interrupt cancelled by IE falling in REQ; later ack ignored
        irq_i = 32'h4; irq_enable_i = 1'b1;
        tick();
        chk("cancel_req", exc_req_o, 1);
        chk("cancel_cause", exc_cause_o, 6'h22);
        irq_i = '0; irq_enable_i = 1'b0;
        tick();
        chk("cancel_idle", strobes(), 8'h00);
        irq_enable_i = 1'b1; exc_ack_i = 1'b1;
        tick();
        chk("cancel_late_ack", strobes(), 8'h00);
        exc_ack_i = 1'b0;

        // One-cycle pulse on line 3 still delivered after a long wait
        irq_i = 32'h8;
        tick();
        irq_i = '0;
        for (int i = 0; i < 4; i++) begin
            chk("pulse_wait", exc_req_o, 1);
            tick();
        end
        exc_ack_i = 1'b1;
        tick();
        exc_ack_i = 1'b0;
        chk("pulse_save", strobes(), 8'b0100_1110);
        chk("pulse_cause", exc_cause_o, 6'h23);
        chk("pulse_id", irq_id_o, 3);
        chk("pulse_addr", trap_addr_o, BASE | 32'h0C);
        tick();

        // Eret beats a pending interrupt for one cycle
        irq_i = 32'h2; id_valid_i = 1'b1; eret_insn_i = 1'b1;
        #1;
        chk("eret_restore", exc_restore_o, 1);
        tick();
        chk("eret_no_latch", exc_req_o, 0);
        id_valid_i = 1'b0; eret_insn_i = 1'b0;
        tick();
        chk("eret_then_req", exc_req_o, 1);
        chk("eret_then_cause", exc_cause_o, 6'h21);
        id_valid_i = 1'b1; eret_insn_i = 1'b1;
        #1;
        chk("restore_blocked_req", exc_restore_o, 0);
        id_valid_i = 1'b0; eret_insn_i = 1'b0;
        exc_ack_i = 1'b1;
        tick();
        exc_ack_i = 1'b0; irq_i = '0;
        rst = 1'b1;
        #1;
        chk("rst_in_save_strobes", strobes(), 8'h00);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_strobes", strobes(), 8'h00);
        chk("post_rst_cause", exc_cause_o, 0);
        chk("post_rst_addr", trap_addr_o, 0);
        chk("post_rst_id", irq_id_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
